// File: rtl/lsu_bus_adapter.sv
// lsu_bus_adapter: turns core loads/stores into valid/ready word-bus transactions with lane steering.
// Define RV_LSU_MISALIGNED_EN to split misaligned half/word accesses into two transactions.
module lsu_bus_adapter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rdEnable,
  input  logic                  i_wrEnable,
  input  logic [1:0]            i_access,
  input  logic                  i_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wrData,
  output logic [31:0]           o_rdData,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_misaligned,
  output logic                  o_busValid,
  output logic                  o_busWr,
  output logic [ADDR_WIDTH-1:0] o_busAddr,
  output logic [3:0]            o_busBE,
  output logic [31:0]           o_busWrData,
  input  logic                  i_busReady,
  input  logic                  i_busRespValid,
  input  logic [31:0]           i_busRdData
);

  // state | meaning
  // IDLE  | no access in flight
  // REQ0  | first bus request presented
  // RESP0 | waiting for first response
  // REQ1  | second request of a split access
  // RESP1 | waiting for second response
  // DONE  | completion pulse, core released
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    RESP0 = 3'd2,
`ifdef RV_LSU_MISALIGNED_EN
    REQ1  = 3'd3,
    RESP1 = 3'd4,
`endif
    DONE  = 3'd5
  } stateType;

  stateType stateQ, stateD;

  logic                  request;
  logic [1:0]            aIn;
  logic                  misIn;
  logic [3:0]            baseMask;
  logic [3:0]            beLowIn;
  logic [31:0]           wrLowIn;
  logic                  capture;
  logic                  finalResp;
  logic [31:0]           shifted;
  logic [31:0]           extended;

  logic                  wrQ;
  logic [1:0]            accessQ;
  logic                  unsignedQ;
  logic [1:0]            aQ;
  logic [ADDR_WIDTH-1:0] busAddrQ;
  logic [3:0]            busBEQ;
  logic [31:0]           busWrDataQ;
  logic [31:0]           rdDataQ;

`ifdef RV_LSU_MISALIGNED_EN
  logic [7:0]            mask8In;
  logic [63:0]           wr64In;
  logic [3:0]            beHiIn;
  logic [31:0]           wrHiIn;
  logic                  startHi;
  logic                  splitQ;
  logic [3:0]            beHiQ;
  logic [31:0]           wrHiQ;
  logic [31:0]           rdLoQ;
  logic [63:0]           merged;
`else
  logic                  misQ;
`endif

  assign request = i_rdEnable | i_wrEnable;
  assign aIn     = i_addr[1:0];
  assign misIn   = ((i_access == 2'b01) && (aIn == 2'b11)) || (i_access[1] && (aIn != 2'b00));

  always_comb begin
    case (i_access)
      2'b00:   baseMask = 4'b0001;
      2'b01:   baseMask = 4'b0011;
      default: baseMask = 4'b1111;
    endcase
  end

`ifdef RV_LSU_MISALIGNED_EN
  assign mask8In = {4'b0000, baseMask} << aIn;
  assign wr64In  = {32'h0, i_wrData} << {aIn, 3'b000};
  assign beLowIn = mask8In[3:0];
  assign beHiIn  = mask8In[7:4];
  assign wrLowIn = wr64In[31:0];
  assign wrHiIn  = wr64In[63:32];
`else
  assign beLowIn = baseMask << aIn;
  assign wrLowIn = i_wrData << {aIn, 3'b000};
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset) stateQ <= IDLE;
    else          stateQ <= stateD;
  end

  always_comb begin
    stateD    = stateQ;
    capture   = 1'b0;
    finalResp = 1'b0;
`ifdef RV_LSU_MISALIGNED_EN
    startHi   = 1'b0;
`endif
    case (stateQ)
      IDLE: begin
        if (request) begin
          capture = 1'b1;
`ifdef RV_LSU_MISALIGNED_EN
          stateD  = REQ0;
`else
          stateD  = misIn ? DONE : REQ0;
`endif
        end
      end
      REQ0: if (i_busReady) stateD = RESP0;
      RESP0: begin
        if (i_busRespValid) begin
`ifdef RV_LSU_MISALIGNED_EN
          if (splitQ) begin
            startHi = 1'b1;
            stateD  = REQ1;
          end else begin
            finalResp = 1'b1;
            stateD    = DONE;
          end
`else
          finalResp = 1'b1;
          stateD    = DONE;
`endif
        end
      end
`ifdef RV_LSU_MISALIGNED_EN
      REQ1: if (i_busReady) stateD = RESP1;
      RESP1: begin
        if (i_busRespValid) begin
          finalResp = 1'b1;
          stateD    = DONE;
        end
      end
`endif
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Lane extraction: split loads merge both words before shifting down.
  always_comb begin
`ifdef RV_LSU_MISALIGNED_EN
    merged  = splitQ ? {i_busRdData, rdLoQ} : {32'h0, i_busRdData};
    shifted = 32'(merged >> {aQ, 3'b000});
`else
    shifted = i_busRdData >> {aQ, 3'b000};
`endif
    case (accessQ)
      2'b00:   extended = unsignedQ ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   extended = unsignedQ ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      wrQ        <= 1'b0;
      accessQ    <= 2'b00;
      unsignedQ  <= 1'b0;
      aQ         <= 2'b00;
      busAddrQ   <= '0;
      busBEQ     <= 4'h0;
      busWrDataQ <= 32'h0;
      rdDataQ    <= 32'h0;
`ifdef RV_LSU_MISALIGNED_EN
      splitQ     <= 1'b0;
      beHiQ      <= 4'h0;
      wrHiQ      <= 32'h0;
      rdLoQ      <= 32'h0;
`else
      misQ       <= 1'b0;
`endif
    end else begin
      if (capture) begin
        wrQ        <= i_wrEnable;
        accessQ    <= i_access;
        unsignedQ  <= i_unsigned;
        aQ         <= aIn;
        busAddrQ   <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
        busBEQ     <= beLowIn;
        busWrDataQ <= wrLowIn;
        rdDataQ    <= 32'h0;
`ifdef RV_LSU_MISALIGNED_EN
        splitQ     <= misIn;
        beHiQ      <= beHiIn;
        wrHiQ      <= wrHiIn;
`else
        misQ       <= misIn;
`endif
      end
`ifdef RV_LSU_MISALIGNED_EN
      if (startHi) begin
        busAddrQ   <= busAddrQ + ADDR_WIDTH'(4);
        busBEQ     <= beHiQ;
        busWrDataQ <= wrHiQ;
        rdLoQ      <= i_busRdData;
      end
`endif
      if (finalResp) rdDataQ <= wrQ ? 32'h0 : extended;
    end
  end

  assign o_busy      = ((stateQ != IDLE) && (stateQ != DONE)) || ((stateQ == IDLE) && request);
  assign o_done      = (stateQ == DONE);
  assign o_rdData    = rdDataQ;
  assign o_busWr     = wrQ;
  assign o_busAddr   = busAddrQ;
  assign o_busBE     = busBEQ;
  assign o_busWrData = busWrDataQ;
`ifdef RV_LSU_MISALIGNED_EN
  assign o_busValid   = (stateQ == REQ0) || (stateQ == REQ1);
  assign o_misaligned = 1'b0;
`else
  assign o_busValid   = (stateQ == REQ0);
  assign o_misaligned = (stateQ == DONE) && misQ;
`endif

endmodule

// File: doc/lsu_bus_adapter.md
# lsu_bus_adapter

Load/store unit sitting between the core's memory-control outputs (read/write enable, access size, unsigned flag, address, store data) and the word-wide data bus. It turns each load or store into one or two bus transactions using a valid/ready request and a response strobe. For stores it generates byte enables and lane-shifted data; for loads it extracts the lanes and zero- or sign-extends them. It stalls the core with `o_busy` until the access completes.

## Interface
- `ADDR_WIDTH`, 32: byte-address width on the core and bus sides.
- `i_clock  input  1`: clock, all logic rising-edge.
- `i_reset  input  1`: synchronous, active-low reset.
- `i_rdEnable  input  1`: load request, level; held stable by core while `o_busy`.
- `i_wrEnable  input  1`: store request, level; wins if asserted together with `i_rdEnable`.
- `i_access  input  2`: `DataAccess`: 00 byte, 01 half, 10 word; 11 treated as word.
- `i_unsigned  input  1`: zero-extend load result (LBU/LHU).
- `i_addr  input  ADDR_WIDTH`: byte address.
- `i_wrData  input  32`: store data, right-aligned.
- `o_rdData  output  32`: load result, valid only while `o_done`.
- `o_busy  output  1`: stall the core.
- `o_done  output  1`: one-cycle completion pulse.
- `o_misaligned  output  1`: one-cycle pulse with `o_done` on a rejected misaligned access.
- `o_busValid  output  1`: bus request valid.
- `o_busWr  output  1`: 1 write, 0 read.
- `o_busAddr  output  ADDR_WIDTH`: word address, bits [1:0] always 0.
- `o_busBE  output  4`: byte enables; also set on reads.
- `o_busWrData  output  32`: lane-aligned store data.
- `i_busReady  input  1`: request accepted when `o_busValid & i_busReady`.
- `i_busRespValid  input  1`: response strobe for both reads and writes.
- `i_busRdData  input  32`: read data, sampled with `i_busRespValid`.

## Operation
- Valid states are IDLE, REQ0, RESP0, REQ1, RESP1 and DONE. Reset forces IDLE.
- **IDLE**
  - With no request, remain in IDLE.
  - With a request, capture all inputs:
    - If aligned, go to REQ0.
    - If misaligned and the feature is absent, go to DONE with the error flag set.
  - Alignment rules:
    - Byte accesses are always aligned.
    - Half accesses are misaligned when addr[1:0]=3.
    - Word accesses are misaligned when addr[1:0]≠0.
- **REQ0**
  - Hold `o_busValid` high with stable address, BE and data until ready, then go to RESP0.
- **RESP0**
  - Wait for `i_busRespValid`.
  - Latch lanes, then go to DONE, or to REQ1 for a split access.
- **REQ1 / RESP1**: second half of a split access, same rules as REQ0/RESP0; go to DONE afterwards.
- **DONE**
  - Assert `o_done` and drive `o_busy`=0.
  - Ignore the request still present (same instruction). Go to IDLE.
- Byte enables by access size, with a = addr[1:0]:
  - Byte: `1<<a`.
  - Half: `3<<a`.
  - Word: `4'hF`.
- Store data: `o_busWrData = i_wrData << 8*a`.
- Load result: take the response `>> 8*a`, keep 8/16/32 bits, then sign-extend from bit 7 or 15 unless `i_unsigned`. Word loads ignore `i_unsigned`.
- `o_busy` = (state∉{IDLE,DONE}) | (state=IDLE & request). This is combinational, so the core stalls in the request cycle.
- `i_busRespValid` outside RESP0/RESP1 is ignored. Only one transaction is outstanding at a time.
- Reset values:
  - State IDLE.
  - `o_busValid`, `o_busWr`, `o_done`, `o_misaligned` = 0.
  - `o_busAddr`, `o_busBE`, `o_busWrData`, `o_rdData` = 0.
- Reset mid-operation: everything returns to reset values at the next edge. A pending bus response is subsequently ignored.

## Timing
- Aligned access with zero-wait bus:
  - Request seen in cycle N.
  - `o_busValid` in N+1.
  - Response in N+2.
  - `o_done` in N+3.
  - The core advances on the N+3 edge.
- Each ready-wait cycle and each response-wait cycle adds one cycle.
- Split access: minimum 5 cycles from request to `o_done`.
- Misaligned rejection: `o_done` and `o_misaligned` in N+1; no bus activity.
- `o_rdData` is registered and valid only in DONE. It is 0 for stores and rejected accesses.

## Configuration
- Macro `RV_LSU_MISALIGNED_EN`.
- **Defined:** misaligned half/word accesses split into two transactions.
  - First transaction: word `addr&~3` with the low-part BE, i.e. BE = (full mask `<<a`)[3:0].
  - Second transaction: word `(addr&~3)+4`, wrapping modulo 2^ADDR_WIDTH, with the spilled BE, i.e. bits [7:4] of the full mask `<<a`.
  - Store data: the 64-bit shifted value is split across the two transactions.
  - Load data: lanes are merged before extension.
  - `o_misaligned` is never asserted.
- **Undefined:** misaligned accesses are rejected as described above. States REQ1/RESP1 are not compiled.

## Test plan
- LW at 0x100 with the bus returning 0xDEADBEEF, zero-wait → BE=F, `o_rdData`=0xDEADBEEF, `o_done` at N+3, `o_busy` high N..N+2.
- LB at 0x103 returning 0x80112233, signed then unsigned → BE=8, `o_rdData`=0xFFFFFF80, then 0x00000080.
- SH 0x1234ABCD at 0x202 with `i_busReady` low for 3 cycles → `o_busValid` held with addr 0x200, BE=C, wdata=0xABCD0000 stable; `o_done` at N+6.
- LW at 0x101, macro undefined → no `o_busValid`, `o_done` and `o_misaligned` at N+1. Macro defined with responses 0x44332211 then 0x88776655 → `o_rdData`=0x55443322.
- SW at 0xFFFFFFFE, macro defined → transactions at 0xFFFFFFFC with BE=C and at 0x00000000 with BE=3.
- Reset asserted during RESP0 → IDLE next cycle, all outputs 0. A late `i_busRespValid` produces no `o_done`.
